// File: rtl/bcd_to_bin_8.sv
// Signed three-digit BCD entry to 8-bit two's-complement converter.
// Uses reverse double dabble (shift right, subtract 3 from nibbles >= 8),
// one bit per clock, followed by a sign/validity resolution cycle.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; captures inputs and validity on start
// S_SHIFT | 8 shift/adjust iterations, binary magnitude builds up
// S_SIGN  | apply sign or flag error, pulse done, return to idle
module bcd_to_bin_8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       neg,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [7:0] Svalue,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_SIGN  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [19:0] sreg_q, sreg_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        bad_q, bad_d;
  logic [7:0]  svalue_q, svalue_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [10:0] mag_in;
  logic        in_bad;
  logic [19:0] shifted;

  // Validity of the raw inputs: digits must be BCD and magnitude must fit the sign.
  always_comb begin
    mag_in = 11'(hundreds) * 11'd100 + 11'(tens) * 11'd10 + 11'(ones);
    in_bad = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9) ||
             (neg ? (mag_in > 11'd128) : (mag_in > 11'd127));
  end

  // One reverse double dabble step: shift right, then correct each BCD nibble.
  always_comb begin
    shifted = {1'b0, sreg_q[19:1]};
    if (shifted[19:16] >= 4'd8) shifted[19:16] = shifted[19:16] - 4'd3;
    if (shifted[15:12] >= 4'd8) shifted[15:12] = shifted[15:12] - 4'd3;
    if (shifted[11:8]  >= 4'd8) shifted[11:8]  = shifted[11:8]  - 4'd3;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    bad_d    = bad_q;
    svalue_d = svalue_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sreg_d  = {hundreds, tens, ones, 8'h00};
          neg_d   = neg;
          bad_d   = in_bad;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = 3'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sreg_d = shifted;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_SIGN;
      end
      S_SIGN: begin
        if (bad_q) begin
          err_d = 1'b1;
        end else begin
          // -128 negates to itself, which is the intended 0x80 result.
          svalue_d = neg_q ? (~sreg_q[7:0] + 8'd1) : sreg_q[7:0];
          err_d    = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sreg_q   <= 20'h0;
      cnt_q    <= 3'd0;
      neg_q    <= 1'b0;
      bad_q    <= 1'b0;
      svalue_q <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      bad_q    <= bad_d;
      svalue_q <= svalue_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign Svalue = svalue_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule
